// File: rtl/data_store_buffer.sv
// data_store_buffer: store FIFO draining to RAM over req/ack, with load forwarding and extension.
// Revision 1.0
`default_nettype none

module data_store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [1:0]            i_access,
  input  logic                  i_unsigned,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_overflow,
  output logic                  o_misaligned,
  output logic                  o_memReq,
  output logic [ADDR_WIDTH-3:0] o_memWaddr,
  output logic [31:0]           o_memWdata,
  output logic [3:0]            o_memBe,
  input  logic                  i_memAck,
  output logic [ADDR_WIDTH-3:0] o_memRaddr,
  input  logic [31:0]           i_memRdata
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WAW = ADDR_WIDTH - 2;

  logic [WAW-1:0] waddr_q [DEPTH];
  logic [31:0]    data_q  [DEPTH];
  logic [3:0]     be_q    [DEPTH];
  logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]    count_q, count_d;
  logic           ovf_q, ovf_d;

  logic           mis, full, push, pop;
  logic [31:0]    st_data;
  logic [3:0]     st_be;
  logic [31:0]    merged, byte_sh, half_sh;
  logic [PW-1:0]  idx;
  logic [WAW-1:0] raddr;

  assign raddr = i_addr[ADDR_WIDTH-1:2];

  always_comb begin
    mis = 1'b0;
    case (i_access)
      2'd0:    mis = 1'b0;
      2'd1:    mis = i_addr[0];
      default: mis = (i_addr[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    st_data = i_wdata;
    st_be   = 4'b1111;
    case (i_access)
      2'd0: begin
        st_data = {4{i_wdata[7:0]}};
        st_be   = 4'b0001 << i_addr[1:0];
      end
      2'd1: begin
        st_data = {2{i_wdata[15:0]}};
        st_be   = i_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = i_wdata;
        st_be   = 4'b1111;
      end
    endcase
  end

  assign full = (count_q == (PW+1)'(DEPTH));
  assign pop  = o_memReq & i_memAck;
  assign push = i_we & ~mis & (~full | pop);

  always_comb begin
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    // A store refused only because the buffer is full counts as an overflow.
    ovf_d = ovf_q | (i_we & ~mis & full & ~pop);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (push) begin
      waddr_q[wptr_q] <= raddr;
      data_q[wptr_q]  <= st_data;
      be_q[wptr_q]    <= st_be;
    end
  end

  // Walk oldest to youngest so the youngest matching store wins each byte.
  always_comb begin
    merged = i_memRdata;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr_q + PW'(i);
      if (((PW+1)'(i) < count_q) && (waddr_q[idx] == raddr)) begin
        for (int b = 0; b < 4; b++) begin
          if (be_q[idx][b]) merged[8*b +: 8] = data_q[idx][8*b +: 8];
        end
      end
    end
  end

  assign byte_sh = merged >> {i_addr[1:0], 3'b000};
  assign half_sh = merged >> {i_addr[1], 4'b0000};

  always_comb begin
    o_rdata = '0;
    if (i_re && !mis) begin
      case (i_access)
        2'd0:    o_rdata = i_unsigned ? {24'b0, byte_sh[7:0]} : {{24{byte_sh[7]}}, byte_sh[7:0]};
        2'd1:    o_rdata = i_unsigned ? {16'b0, half_sh[15:0]} : {{16{half_sh[15]}}, half_sh[15:0]};
        default: o_rdata = merged;
      endcase
    end
  end

  assign o_full       = full;
  assign o_empty      = (count_q == '0);
  assign o_overflow   = ovf_q;
  assign o_misaligned = mis;
  assign o_memReq     = (count_q != '0);
  assign o_memWaddr   = waddr_q[rptr_q];
  assign o_memWdata   = data_q[rptr_q];
  assign o_memBe      = be_q[rptr_q];
  assign o_memRaddr   = raddr;

endmodule

`default_nettype wire
